regfile_write_arbiter: RTL

//  Shares the single register-file write port (clk_i, RD_addr/RD_data/RegWrite) among the

---
 rtl/regfile_arb_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_rr.sv | 55 +++++
 rtl/regfile_write_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/regfile_arb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_arb_pkg
//   Shared definitions for the register-file write-port arbiter.
//   - DEF_ADDR_W / DEF_DATA_W : default register address / data widths
//   - arb_state_t             : starvation FSM states (NORMAL / COUNT / FORCE)
//   - idx_width()             : index width for an n-entry vector (min 1 bit)
// ---------------------------------------------------------------------------
package regfile_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    COUNT  = 2'd1,
    FORCE  = 2'd2
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick over N request lines. The search starts
//   at index ptr and wraps from N-1 back to 0; the first valid line wins.
//   Ports:
//     valid     in  N      request vector
//     ptr       in  IDX_W  index with highest priority this cycle
//     grant     out N      one-hot grant, zero when nothing is valid
//     grant_idx out IDX_W  binary index of the granted line
//     any       out 1      at least one request valid
// ---------------------------------------------------------------------------
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [N-1:0]     mask;
  logic [N-1:0]     masked;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Lines at or above the pointer get first chance; if none of them is
  // valid the lowest valid line overall is the wrapped-around winner.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = (gi >= int'(ptr));
    end
  endgenerate

  assign masked = valid & mask;

  // Scan downward so the last assignment is the lowest set index.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (masked[k]) hi_idx = IDX_W'(k);
      if (valid[k])  lo_idx = IDX_W'(k);
    end
  end

  assign any       = |valid;
  assign grant_idx = (|masked) ? hi_idx : lo_idx;
  assign grant     = any ? (N'(1) << grant_idx) : '0;

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the single register-file write port between the WB stage (port 0,
//   fixed top priority, never backpressured) and NUM_REQ-1 side requesters
//   (valid/ready, round-robin). A starvation FSM raises stall_o for one cycle
//   after STARVE_LIMIT consecutive side losses so a waiting side port wins.
//   The selected write reaches the register file one cycle later.
//   Ports:
//     clk_i, rst_n_i          clock, asynchronous active-low reset
//     wb_we_i/addr_i/data_i   WB stage write request
//     side_valid_i            side request valid, bit k-1 = port k
//     side_addr_i/data_i      packed side payloads, port k at slice k-1
//     side_ready_o            one-hot-or-zero side grant
//     stall_o                 one-cycle forced pipeline stall
//     rf_we_o/addr_o/data_o   register file write port
//     err_o                   sticky: WB write presented during stall_o
// ---------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          wb_we_i,
  input  logic [ADDR_W-1:0]             wb_addr_i,
  input  logic [DATA_W-1:0]             wb_data_i,
  input  logic [NUM_REQ-2:0]            side_valid_i,
  input  logic [(NUM_REQ-1)*ADDR_W-1:0] side_addr_i,
  input  logic [(NUM_REQ-1)*DATA_W-1:0] side_data_i,
  output logic [NUM_REQ-2:0]            side_ready_o,
  output logic                          stall_o,
  output logic                          rf_we_o,
  output logic [ADDR_W-1:0]             rf_addr_o,
  output logic [DATA_W-1:0]             rf_data_o,
  output logic                          err_o
);

  localparam int NS    = NUM_REQ - 1;
  localparam int IDX_W = idx_width(NS);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  // Round-robin pointer held as a 0-based side index: value 0 is port 1.
  logic [IDX_W-1:0]  rr_idx_reg;
  arb_state_t        state_reg;
  logic [CNT_W-1:0]  starve_cnt_reg;
  logic              stall_reg;
  logic              err_reg;
  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_addr_reg;
  logic [DATA_W-1:0] rf_data_reg;

  logic [ADDR_W-1:0] side_addr_arr [NS];
  logic [DATA_W-1:0] side_data_arr [NS];

  logic [NS-1:0]     arb_grant;
  logic [IDX_W-1:0]  arb_grant_idx;
  logic              arb_any;

  logic              side_xfer;
  logic              side_loss;
  logic              win;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_write;
  logic [CNT_W-1:0]  eff_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_unpack
      assign side_addr_arr[gi] = side_addr_i[gi*ADDR_W +: ADDR_W];
      assign side_data_arr[gi] = side_data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .N     (NS),
    .IDX_W (IDX_W)
  ) u_rr (
    .valid     (side_valid_i),
    .ptr       (rr_idx_reg),
    .grant     (arb_grant),
    .grant_idx (arb_grant_idx),
    .any       (arb_any)
  );

  // WB pre-empts every side port; during reset no grant is visible.
  assign side_ready_o = (rst_n_i && !wb_we_i) ? arb_grant : '0;
  assign side_xfer    = arb_any & ~wb_we_i;
  assign side_loss    = arb_any & wb_we_i;

  assign win       = wb_we_i | side_xfer;
  assign win_addr  = wb_we_i ? wb_addr_i : side_addr_arr[arb_grant_idx];
  assign win_data  = wb_we_i ? wb_data_i : side_data_arr[arb_grant_idx];
  // Writes to $zero are accepted from the requester but never reach the file.
  assign win_write = win && (win_addr != '0);

  // A loss seen while stalled (WB misbehaving) starts a fresh starvation run.
  assign eff_cnt = (state_reg == FORCE) ? '0 : starve_cnt_reg;

  // Starvation FSM with registered stall/err outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= NORMAL;
      starve_cnt_reg <= '0;
      stall_reg      <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      if (wb_we_i && stall_reg) err_reg <= 1'b1;
      if (side_loss) begin
        if (eff_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
          state_reg      <= FORCE;
          stall_reg      <= 1'b1;
          starve_cnt_reg <= '0;
        end else begin
          state_reg      <= COUNT;
          stall_reg      <= 1'b0;
          starve_cnt_reg <= eff_cnt + 1'b1;
        end
      end else begin
        state_reg      <= NORMAL;
        stall_reg      <= 1'b0;
        starve_cnt_reg <= '0;
      end
    end
  end

  // Write-port output register and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rf_we_reg   <= 1'b0;
      rf_addr_reg <= '0;
      rf_data_reg <= '0;
      rr_idx_reg  <= '0;
    end else begin
      rf_we_reg <= win_write;
      if (win_write) begin
        rf_addr_reg <= win_addr;
        rf_data_reg <= win_data;
      end
      if (side_xfer) begin
        rr_idx_reg <= (arb_grant_idx == IDX_W'(NS - 1)) ? '0 : arb_grant_idx + 1'b1;
      end
    end
  end

  assign stall_o   = stall_reg;
  assign err_o     = err_reg;
  assign rf_we_o   = rf_we_reg;
  assign rf_addr_o = rf_addr_reg;
  assign rf_data_o = rf_data_reg;

endmodule
